// File: rtl/w_retire_monitor.sv
`timescale 1ns/1ps
// w_retire_monitor
//   Sits beside the writeback stage and watches instructions retire. It counts
//   retired instructions and run cycles, and spots the terminating self-loop:
//   the same PC retiring HALT_REPEAT times in a row. It then waits
//   DRAIN_CYCLES cycles in DRAIN and raises halted. A retire at a different
//   PC during DRAIN means the loop was not final, and the monitor returns to
//   RUN.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low (0 = in reset)
//   clr          synchronous clear back to IDLE; takes priority over w_valid
//   w_valid      an instruction retires in W this cycle
//   w_pc         PC of the retiring instruction
//   running      1 in RUN or DRAIN
//   halted       1 in HALTED
//   retired_cnt  instructions retired since leaving IDLE (saturating)
//   cycle_cnt    cycles elapsed since leaving IDLE (saturating)
//   halt_pc      PC of the most recently detected self-loop
module w_retire_monitor #(
  parameter int PC_W         = 32,
  parameter int CNT_W        = 32,
  parameter int HALT_REPEAT  = 4,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             w_valid,
  input  logic [PC_W-1:0]  w_pc,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [PC_W-1:0]  halt_pc
);

  localparam int SW = $clog2(HALT_REPEAT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(HALT_REPEAT);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [PC_W-1:0]   halt_pc_q, halt_pc_d;
  logic [PC_W-1:0]   last_pc_q, last_pc_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [DW-1:0]     drain_q, drain_d;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [SW-1:0] sat_inc_streak(input logic [SW-1:0] v);
    return (v >= STREAK_MAX) ? STREAK_MAX : v + SW'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cyc_d     = cyc_q;
    halt_pc_d = halt_pc_q;
    last_pc_d = last_pc_q;
    streak_d  = streak_q;
    drain_d   = drain_q;

    if (clr) begin
      state_d   = IDLE;
      ret_d     = '0;
      cyc_d     = '0;
      halt_pc_d = '0;
      last_pc_d = '0;
      streak_d  = '0;
      drain_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // The retire that starts the run is itself counted.
          if (w_valid) begin
            state_d   = RUN;
            ret_d     = CNT_W'(1);
            cyc_d     = CNT_W'(1);
            last_pc_d = w_pc;
            streak_d  = SW'(1);
          end
        end
        RUN: begin
          cyc_d = sat_inc_cnt(cyc_q);
          if (w_valid) begin
            ret_d = sat_inc_cnt(ret_q);
            if (w_pc == last_pc_q) begin
              streak_d = sat_inc_streak(streak_q);
            end else begin
              streak_d  = SW'(1);
              last_pc_d = w_pc;
            end
            if (streak_d == STREAK_MAX) begin
              state_d   = DRAIN;
              halt_pc_d = w_pc;
              drain_d   = '0;
            end
          end
        end
        DRAIN: begin
          cyc_d = sat_inc_cnt(cyc_q);
          if (w_valid) begin
            ret_d = sat_inc_cnt(ret_q);
          end
          if (w_valid && (w_pc != halt_pc_q)) begin
            // Loop was not terminal; halt_pc is kept until the next detection.
            state_d   = RUN;
            streak_d  = SW'(1);
            last_pc_d = w_pc;
          end else begin
            if (w_valid) begin
              streak_d = sat_inc_streak(streak_q);
            end
            if (drain_q == DRAIN_LAST) begin
              state_d = HALTED;
            end else begin
              drain_d = drain_q + DW'(1);
            end
          end
        end
        HALTED: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Register boundary: all observable state updates here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ret_q     <= '0;
      cyc_q     <= '0;
      halt_pc_q <= '0;
      last_pc_q <= '0;
      streak_q  <= '0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      cyc_q     <= cyc_d;
      halt_pc_q <= halt_pc_d;
      last_pc_q <= last_pc_d;
      streak_q  <= streak_d;
      drain_q   <= drain_d;
    end
  end

  assign running     = (state_q == RUN) || (state_q == DRAIN);
  assign halted      = (state_q == HALTED);
  assign retired_cnt = ret_q;
  assign cycle_cnt   = cyc_q;
  assign halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_w_retire_monitor.sv
`timescale 1ns/1ps
module tb_w_retire_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr = 1'b0;
  logic        w_valid = 1'b0;
  logic [31:0] w_pc = '0;

  logic        running, halted;
  logic [31:0] retired_cnt, cycle_cnt, halt_pc;

  logic        running4, halted4;
  logic [3:0]  retired_cnt4, cycle_cnt4;
  logic [31:0] halt_pc4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  w_retire_monitor u_dut (
    .clk(clk), .reset(reset), .clr(clr), .w_valid(w_valid), .w_pc(w_pc),
    .running(running), .halted(halted), .retired_cnt(retired_cnt),
    .cycle_cnt(cycle_cnt), .halt_pc(halt_pc)
  );

  w_retire_monitor #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .clr(clr), .w_valid(w_valid), .w_pc(w_pc),
    .running(running4), .halted(halted4), .retired_cnt(retired_cnt4),
    .cycle_cnt(cycle_cnt4), .halt_pc(halt_pc4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one clock edge; outputs are checked 1ns after that edge.
  task automatic cyc(input logic v, input logic [31:0] pc);
    w_valid = v;
    w_pc    = pc;
    @(posedge clk);
    #1;
    w_valid = 1'b0;
  endtask

  task automatic do_clr(input logic v, input logic [31:0] pc);
    clr = 1'b1;
    cyc(v, pc);
    clr = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic run, input logic hlt,
                           input logic [31:0] ret, input logic [31:0] cy,
                           input logic [31:0] hpc);
    chk({tag, ".running"}, running, run);
    chk({tag, ".halted"}, halted, hlt);
    chk({tag, ".retired"}, retired_cnt, ret);
    chk({tag, ".cycles"}, cycle_cnt, cy);
    chk({tag, ".halt_pc"}, halt_pc, hpc);
  endtask

  initial begin
    // 1: reset, then idle
    repeat (3) @(posedge clk);
    #1;
    chk_state("rst", 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (10) cyc(0, 32'h0);
    chk_state("idle", 0, 0, 0, 0, 0);

    // 2: three back-to-back retires
    cyc(1, 32'h3000);
    chk_state("run1", 1, 0, 1, 1, 0);
    cyc(1, 32'h3004);
    cyc(1, 32'h3008);
    chk_state("run3", 1, 0, 3, 3, 0);
    cyc(0, 32'h0);
    chk_state("run3b", 1, 0, 3, 4, 0);

    // 5a: clr with a simultaneous retire in RUN
    do_clr(1, 32'h5000);
    chk_state("clr_run", 0, 0, 0, 0, 0);
    cyc(0, 32'h0);
    chk_state("clr_run_idle", 0, 0, 0, 0, 0);

    // 3: run into a self-loop and halt
    for (int i = 0; i < 4; i++) cyc(1, 32'h3000 + 32'(4 * i));
    for (int i = 0; i < 3; i++) cyc(1, 32'h3010);
    chk_state("pre_det", 1, 0, 7, 7, 0);
    cyc(1, 32'h3010);
    chk_state("det", 1, 0, 8, 8, 32'h3010);
    repeat (4) cyc(0, 32'h0);
    chk_state("drain4", 1, 0, 8, 12, 32'h3010);
    cyc(0, 32'h0);
    chk_state("halted", 0, 1, 8, 13, 32'h3010);
    cyc(1, 32'h3010);
    cyc(1, 32'h4000);
    chk_state("halted_frz", 0, 1, 8, 13, 32'h3010);

    // 5b: clr with a retire in HALTED
    do_clr(1, 32'h3010);
    chk_state("clr_halt", 0, 0, 0, 0, 0);

    // 4: bubbles inside the streak, then a false halt
    cyc(1, 32'h3010);
    cyc(0, 32'h0);
    cyc(1, 32'h3010);
    cyc(0, 32'h0);
    cyc(1, 32'h3010);
    cyc(1, 32'h3010);
    chk_state("bub_det", 1, 0, 4, 6, 32'h3010);
    cyc(0, 32'h0);
    cyc(0, 32'h0);
    cyc(1, 32'h3014);
    chk_state("false_halt", 1, 0, 5, 9, 32'h3010);
    repeat (6) cyc(0, 32'h0);
    chk_state("false_run", 1, 0, 5, 15, 32'h3010);
    // Three more of 0x3014 reach the threshold only if the streak restarted at 1.
    repeat (2) cyc(1, 32'h3014);
    chk_state("streak3", 1, 0, 7, 17, 32'h3010);
    cyc(1, 32'h3014);
    chk_state("det2", 1, 0, 8, 18, 32'h3014);
    // Same-PC retires during DRAIN do not restart it.
    cyc(1, 32'h3014);
    cyc(0, 32'h0);
    cyc(1, 32'h3014);
    cyc(0, 32'h0);
    chk_state("drain_same", 1, 0, 10, 22, 32'h3014);
    cyc(0, 32'h0);
    chk_state("halt2", 0, 1, 10, 23, 32'h3014);
    do_clr(0, 32'h0);

    // 6: saturation on the 4-bit build, then reset during DRAIN
    for (int i = 0; i < 18; i++) cyc(1, 32'h100 + 32'(4 * i));
    chk("sat.retired4", retired_cnt4, 15);
    chk("sat.cycles4", cycle_cnt4, 15);
    chk("sat.running4", running4, 1);
    chk("sat.retired32", retired_cnt, 18);
    repeat (4) cyc(1, 32'h3010);
    chk("sat_det.retired4", retired_cnt4, 15);
    chk("sat_det.cycles4", cycle_cnt4, 15);
    chk("sat_det.halt_pc4", halt_pc4, 32'h3010);
    chk_state("sat_det", 1, 0, 22, 22, 32'h3010);
    cyc(0, 32'h0);
    #2 reset = 1'b0;
    #1;
    chk_state("async_rst", 0, 0, 0, 0, 0);
    chk("async_rst.retired4", retired_cnt4, 0);
    chk("async_rst.running4", running4, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(0, 32'h0);
    chk_state("post_rst", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running sim expected finish");
    $fatal(1, "timeout");
  end

endmodule
